// File: rtl/wave_ram_writer_pkg.sv
// rtl/wave_ram_writer_pkg.sv - shared waveform table parameters and writer state encoding
package wave_ram_writer_pkg;

  // Table geometry shared with the waveform ROM and the pointer generator
  localparam int WAVE_WIDTH = 32;
  localparam int WAVE_DEPTH = 64;
  localparam int WAVE_AW    = 6;

  // Fill controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } state_e;

  // True when a pointer sits on the last address of a power-of-two table
  function automatic logic is_last_addr(input logic [WAVE_AW-1:0] ptr);
    return &ptr;
  endfunction

endpackage

// File: rtl/wave_ram_writer_if.sv
// rtl/wave_ram_writer_if.sv - sample stream, status and read port bundle of the waveform RAM writer
interface wave_ram_writer_if
  import wave_ram_writer_pkg::*;
#(
  parameter int WIDTH = WAVE_WIDTH,
  parameter int AW    = WAVE_AW
);

  logic             start;
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             busy;
  logic             done;
  logic [AW:0]      wr_count;
  logic             rd_en;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_data;

  // Side that loads the table and reads it back
  modport master (
    output start, din, din_valid, rd_en, rd_addr,
    input  din_ready, busy, done, wr_count, rd_data
  );

  // The writer block itself
  modport slave (
    input  start, din, din_valid, rd_en, rd_addr,
    output din_ready, busy, done, wr_count, rd_data
  );

endinterface

// File: rtl/wave_ram_writer_ram.sv
// rtl/wave_ram_writer_ram.sv - simple dual-port read-first table RAM with registered output
module wave_ram
  import wave_ram_writer_pkg::*;
#(
  parameter int WIDTH = WAVE_WIDTH,
  parameter int AW    = WAVE_AW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << AW;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Write port; the array has no reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read port; reading in the same edge as a write returns the old word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/wave_ram_writer.sv
// rtl/wave_ram_writer.sv - run-time loader for the waveform table: fill FSM, write pointer, word count
module wave_ram_writer
  import wave_ram_writer_pkg::*;
#(
  parameter int WIDTH = WAVE_WIDTH,
  parameter int DEPTH = WAVE_DEPTH,
  parameter int AW    = WAVE_AW
) (
  input  logic               clk,
  input  logic               rst,
  wave_ram_writer_if.slave   bus
);

  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW:0]   wr_count_q, wr_count_d;
  logic          we;

  // State, write pointer and word counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wptr_q     <= '0;
      wr_count_q <= '0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      wr_count_q <= wr_count_d;
    end
  end

  // Next-state logic: start always restarts at address 0, and a beat
  // arriving together with start is dropped rather than written
  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    wr_count_d = wr_count_q;
    we         = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d    = FILL;
          wptr_d     = '0;
          wr_count_d = '0;
        end
      end
      FILL: begin
        if (bus.start) begin
          wptr_d     = '0;
          wr_count_d = '0;
        end else if (bus.din_valid) begin
          we         = 1'b1;
          wptr_d     = wptr_q + PTR_ONE;
          wr_count_d = wr_count_q + CNT_ONE;
          if (wptr_q == LAST_ADDR) begin
            state_d = FULL;
          end
        end
      end
      FULL: begin
        if (bus.start) begin
          state_d    = FILL;
          wptr_d     = '0;
          wr_count_d = '0;
        end
      end
      default: begin
        state_d    = IDLE;
        wptr_d     = '0;
        wr_count_d = '0;
      end
    endcase
  end

  // Status outputs decoded straight from the state register
  assign bus.din_ready = (state_q == FILL);
  assign bus.busy      = (state_q == FILL);
  assign bus.done      = (state_q == FULL);
  assign bus.wr_count  = wr_count_q;

  wave_ram #(
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (wptr_q),
    .wdata (bus.din),
    .re    (bus.rd_en),
    .raddr (bus.rd_addr),
    .rdata (bus.rd_data)
  );

endmodule

// File: tb/tb_wave_ram_writer.sv
// tb/tb_wave_ram_writer.sv - self-checking bench for the waveform RAM writer
module tb_wave_ram_writer;
  import wave_ram_writer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  wave_ram_writer_if bus ();

  wave_ram_writer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] exp_mem [64];
  logic [31:0] sb_q [$];

  typedef struct {
    logic        st;
    logic        v;
    logic [31:0] d;
    logic        e_ready;
    logic        e_busy;
    logic        e_done;
    logic [6:0]  e_cnt;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // One clock: drive inputs, scoreboard the read, sample 1 ns after the edge
  task automatic cyc(input logic st, input logic v, input logic [31:0] d,
                     input logic re, input logic [5:0] ra);
    logic [31:0] e;
    bus.start     = st;
    bus.din_valid = v;
    bus.din       = d;
    bus.rd_en     = re;
    bus.rd_addr   = ra;
    if (re) sb_q.push_back(exp_mem[ra]);
    @(posedge clk);
    #1;
    bus.start     = 1'b0;
    bus.din_valid = 1'b0;
    bus.rd_en     = 1'b0;
    if (re) begin
      e = sb_q.pop_front();
      check("rd_data", {32'd0, bus.rd_data}, {32'd0, e});
    end
  endtask

  task automatic read_all();
    for (int a = 0; a < 64; a++) cyc(1'b0, 1'b0, 32'd0, 1'b1, 6'(a));
  endtask

  // Full fill of 64 words, optional start cycle and idle gaps between beats
  task automatic fill(input logic do_start, input logic mul3, input logic [31:0] base, input int gap);
    logic [31:0] d;
    if (do_start) begin
      cyc(1'b1, 1'b0, 32'd0, 1'b0, 6'd0);
      check("start_ready", {63'd0, bus.din_ready}, 64'd1);
      check("start_count", {57'd0, bus.wr_count}, 64'd0);
    end
    for (int i = 0; i < 64; i++) begin
      for (int g = 0; g < gap; g++) begin
        cyc(1'b0, 1'b0, 32'hDEAD_0000, 1'b0, 6'd0);
        check("gap_busy", {63'd0, bus.busy}, 64'd1);
        check("gap_done", {63'd0, bus.done}, 64'd0);
        check("gap_count", {57'd0, bus.wr_count}, 64'(i));
      end
      d = mul3 ? 32'(i * 3) : base + 32'(i);
      cyc(1'b0, 1'b1, d, 1'b0, 6'd0);
      exp_mem[i] = d;
      check("beat_count", {57'd0, bus.wr_count}, 64'(i + 1));
      check("beat_done", {63'd0, bus.done}, (i == 63) ? 64'd1 : 64'd0);
      check("beat_busy", {63'd0, bus.busy}, (i == 63) ? 64'd0 : 64'd1);
    end
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.din       = '0;
    bus.din_valid = 1'b0;
    bus.rd_en     = 1'b0;
    bus.rd_addr   = '0;
    for (int i = 0; i < 64; i++) exp_mem[i] = '0;

    //        st    v     d              rdy   busy  done  cnt
    vecs[0] = '{1'b0, 1'b1, 32'h0000_0999, 1'b0, 1'b0, 1'b0, 7'd0};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 7'd0};
    vecs[2] = '{1'b0, 1'b1, 32'h0000_0100, 1'b1, 1'b1, 1'b0, 7'd1};
    vecs[3] = '{1'b0, 1'b0, 32'h0000_0555, 1'b1, 1'b1, 1'b0, 7'd1};
    vecs[4] = '{1'b0, 1'b1, 32'h0000_0101, 1'b1, 1'b1, 1'b0, 7'd2};
    vecs[5] = '{1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0, 7'd0};
    vecs[6] = '{1'b0, 1'b1, 32'h0000_0200, 1'b1, 1'b1, 1'b0, 7'd1};
    vecs[7] = '{1'b0, 1'b1, 32'h0000_0201, 1'b1, 1'b1, 1'b0, 7'd2};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {63'd0, bus.din_ready}, 64'd0);
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_done", {63'd0, bus.done}, 64'd0);
    check("rst_count", {57'd0, bus.wr_count}, 64'd0);
    check("rst_rd_data", {32'd0, bus.rd_data}, 64'd0);
    rst = 1'b0;

    // Table-driven start / beat / coincident-restart sequence
    for (int k = 0; k < 8; k++) begin
      cyc(vecs[k].st, vecs[k].v, vecs[k].d, 1'b0, 6'd0);
      check($sformatf("vec%0d_ready", k), {63'd0, bus.din_ready}, {63'd0, vecs[k].e_ready});
      check($sformatf("vec%0d_busy", k), {63'd0, bus.busy}, {63'd0, vecs[k].e_busy});
      check($sformatf("vec%0d_done", k), {63'd0, bus.done}, {63'd0, vecs[k].e_done});
      check($sformatf("vec%0d_count", k), {57'd0, bus.wr_count}, {57'd0, vecs[k].e_cnt});
    end
    exp_mem[0] = 32'h0000_0200;
    exp_mem[1] = 32'h0000_0201;
    cyc(1'b0, 1'b0, 32'd0, 1'b1, 6'd0);
    cyc(1'b0, 1'b0, 32'd0, 1'b1, 6'd1);

    // Full back-to-back fill with din = addr*3, then read back
    fill(1'b1, 1'b1, 32'd0, 0);
    check("full_count", {57'd0, bus.wr_count}, 64'd64);
    read_all();

    // FULL hold: input ignored, table unchanged
    for (int k = 0; k < 5; k++) begin
      cyc(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 6'd0);
      check("hold_ready", {63'd0, bus.din_ready}, 64'd0);
      check("hold_done", {63'd0, bus.done}, 64'd1);
      check("hold_count", {57'd0, bus.wr_count}, 64'd64);
    end
    read_all();

    // Start from FULL resumes at address 0
    cyc(1'b1, 1'b1, 32'hFFFF_0000, 1'b0, 6'd0);
    check("resume_done", {63'd0, bus.done}, 64'd0);
    check("resume_count", {57'd0, bus.wr_count}, 64'd0);
    cyc(1'b0, 1'b1, 32'h0000_0077, 1'b0, 6'd0);
    exp_mem[0] = 32'h0000_0077;
    check("resume_count1", {57'd0, bus.wr_count}, 64'd1);
    cyc(1'b0, 1'b0, 32'd0, 1'b1, 6'd0);
    cyc(1'b0, 1'b0, 32'd0, 1'b1, 6'd1);

    // rd_en low holds rd_data
    cyc(1'b0, 1'b0, 32'd0, 1'b0, 6'd9);
    check("rd_hold", {32'd0, bus.rd_data}, {32'd0, exp_mem[1]});

    // Asynchronous reset in the middle of a cycle
    #2;
    rst = 1'b1;
    #1;
    check("arst_ready", {63'd0, bus.din_ready}, 64'd0);
    check("arst_busy", {63'd0, bus.busy}, 64'd0);
    check("arst_count", {57'd0, bus.wr_count}, 64'd0);
    check("arst_rd_data", {32'd0, bus.rd_data}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(1'b0, 1'b1, 32'h0000_0055, 1'b0, 6'd0);
    check("post_rst_ready", {63'd0, bus.din_ready}, 64'd0);
    check("post_rst_count", {57'd0, bus.wr_count}, 64'd0);
    check("post_rst_busy", {63'd0, bus.busy}, 64'd0);

    // Gapped input: one beat every third cycle
    fill(1'b1, 1'b0, 32'h0000_1000, 2);
    read_all();

    // Restart after 20 beats; the beat coincident with start is dropped
    cyc(1'b1, 1'b0, 32'd0, 1'b0, 6'd0);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 1'b1, 32'hBBBB_0000 + 32'(i), 1'b0, 6'd0);
      exp_mem[i] = 32'hBBBB_0000 + 32'(i);
    end
    check("pre_restart_count", {57'd0, bus.wr_count}, 64'd20);
    cyc(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 6'd0);
    check("restart_count", {57'd0, bus.wr_count}, 64'd0);
    check("restart_busy", {63'd0, bus.busy}, 64'd1);
    fill(1'b0, 1'b0, 32'hA5A5_0000, 0);
    read_all();

    // Read-during-write at address 5: old word first, new word next
    fill(1'b1, 1'b0, 32'h0000_000C, 0);
    cyc(1'b1, 1'b0, 32'd0, 1'b0, 6'd0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b1, 32'h0000_0300 + 32'(i), 1'b0, 6'd0);
      exp_mem[i] = 32'h0000_0300 + 32'(i);
    end
    check("rdw_old_value", {32'd0, exp_mem[5]}, 64'h11);
    cyc(1'b0, 1'b1, 32'h0000_0022, 1'b1, 6'd5);
    exp_mem[5] = 32'h0000_0022;
    cyc(1'b0, 1'b0, 32'd0, 1'b1, 6'd5);
    check("rdw_count", {57'd0, bus.wr_count}, 64'd6);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
